uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameters SHALL be one per line (name, default, meaning):
- CLK_HZ, 100000000, system clock frequency.
- DATA_W, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.
REQ-002 Ports SHALL be one per line (name, direction, width, meaning):
- clk, in, 1, single system clock; all logic on its rising edge.
- reset, in, 1, asynchronous, active-low reset.
- baud_select, in, 3, 000..111 = 300/1200/4800/9600/19200/38400/57600/115200 baud.
- Rx_EN, in, 1, receiver enable.
- parity_mode, in, 2, 00 none, 01 even, 10 odd, 11 treated as none.
- stop2, in, 1, 1 = two stop bits expected.
- RxD, in, 1, serial input; idle high.
- Rx_READY, in, 1, consumer pops the FIFO head.
- Rx_DATA, out, DATA_W, data of the FIFO head entry.
- Rx_PERROR, out, 1, parity error flag of the head entry.
- Rx_FERROR, out, 1, framing error flag of the head entry.
- Rx_VALID, out, 1, FIFO not empty.
- Rx_OVERRUN, out, 1, sticky flag: a frame was dropped because the FIFO was full.
- fifo_count, out, clog2(FIFO_DEPTH)+1, number of occupied entries.

Function
REQ-003 RxD SHALL pass through a 2-flop synchronizer; all frame logic SHALL use the synchronized value.
REQ-004 Sample tick SHALL assert for one clk every round(CLK_HZ/(16*baud)) cycles, giving 16 ticks per bit.
REQ-005 The tick divisor SHALL latch baud_select, parity_mode and stop2 only in IDLE; changes mid-frame SHALL take effect on the next frame.
REQ-006 FSM states SHALL be IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-007 IDLE -> START SHALL occur on a high-to-low transition of the synchronized RxD while Rx_EN=1.
REQ-008 In START, if RxD is high at tick 8, the FSM SHALL return to IDLE (glitch rejection) with no FIFO write.
REQ-009 In DATA, each bit SHALL be sampled at tick 8 of its bit period; DATA_W bits, LSB first.
REQ-010 PARITY SHALL be visited only when parity_mode is 01 or 10.
REQ-011 PERROR SHALL be set when the received bit differs from the computed parity (even: XOR of data; odd: its inverse).
REQ-012 FERROR SHALL be set if any expected stop bit samples low at tick 8; STOP2 SHALL be visited only when stop2=1.
REQ-013 At tick 8 of the last stop bit, {data, PERROR, FERROR} SHALL be written to the FIFO and the FSM SHALL return to IDLE; this gives no half-bit wait, so back-to-back frames are accepted.
REQ-014 FIFO SHALL be first-word-fall-through: Rx_DATA, Rx_PERROR and Rx_FERROR show the head whenever Rx_VALID=1.
REQ-015 A pop SHALL occur when Rx_READY & Rx_VALID; Rx_READY while empty SHALL be ignored.
REQ-016 Frame write while full, with no pop in the same cycle: the frame SHALL be dropped and Rx_OVERRUN set; FIFO contents SHALL be unchanged.
REQ-017 Write and pop in the same cycle SHALL both succeed at any occupancy, including full, with fifo_count unchanged.
REQ-018 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Rx_OVERRUN SHALL clear only on reset or on Rx_EN=0.
REQ-020 Rx_EN=0 SHALL force IDLE on the next clk and discard any partial frame; FIFO contents and pops SHALL be retained.

Reset
REQ-021 While reset=0, the FSM SHALL be in IDLE, the synchronizer SHALL hold 1, and the divisor and FIFO pointers SHALL be 0.
REQ-022 While reset=0, outputs SHALL be: Rx_VALID=0, Rx_DATA=0, Rx_PERROR=0, Rx_FERROR=0, Rx_OVERRUN=0, fifo_count=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no FIFO write; after release the receiver SHALL wait for a new falling edge.

Verification
REQ-024 The bench SHALL run CLK_HZ=100e6 (10 ns clk), baud_select=111, DATA_W=8, FIFO_DEPTH=4, and cover:
- 0x55, even parity, parity bit 0, 1 stop -> Rx_VALID=1, Rx_DATA=0x55, PERROR=0, FERROR=0, fifo_count=1.
- 0xA3, odd parity with a wrong parity bit -> Rx_DATA=0xA3, PERROR=1; then 0x0F with stop bit low -> FERROR=1.
- RxD low for 4 ticks in IDLE -> no write, Rx_VALID stays 0.
- 5 frames 0x01..0x05, Rx_READY=0 -> fifo_count=4, Rx_OVERRUN=1; pops return 0x01..0x04 in order.
- reset=0 for 100 ns in the middle of DATA -> all outputs 0; the next full frame 0x3C is received correctly.
- Rx_READY held high during a full-FIFO frame write -> simultaneous write and pop, no overrun, fifo_count stays 4.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, optional parity, one or two stop bits,
// feeding a first-word-fall-through FIFO with per-entry parity/framing flags.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   baud_select,
  input  logic                         Rx_EN,
  input  logic [1:0]                   parity_mode,
  input  logic                         stop2,
  input  logic                         RxD,
  input  logic                         Rx_READY,
  output logic [DATA_W-1:0]            Rx_DATA,
  output logic                         Rx_PERROR,
  output logic                         Rx_FERROR,
  output logic                         Rx_VALID,
  output logic                         Rx_OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  function automatic int div_of(input int baud);
    return (CLK_HZ + 8 * baud) / (16 * baud);
  endfunction

  localparam int DIV_MAX = div_of(300);
  localparam int CNT_W   = $clog2(DIV_MAX + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int BIT_W   = $clog2(DATA_W);
  localparam int ENT_W   = DATA_W + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  state_t             r_state, w_state_next;
  logic               r_rxd_s1, r_rxd_s2, r_rxd_d;
  logic [2:0]         r_baud_lat;
  logic [1:0]         r_par_lat;
  logic               r_stop2_lat;
  logic [CNT_W-1:0]   r_div_cnt, w_div_val;
  logic [3:0]         r_tick;
  logic [BIT_W-1:0]   r_bit;
  logic [DATA_W-1:0]  r_shift;
  logic               r_perr, r_ferr;
  logic               w_rxd, w_fall, w_tick, w_mid, w_end;
  logic               w_par_en, w_par_exp, w_frame_done, w_done_ferr;

  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_overrun;
  logic               w_valid, w_full, w_pop, w_push;
  logic [ENT_W-1:0]   w_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
    end else begin
      r_rxd_s1 <= RxD;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
    end
  end

  assign w_rxd  = r_rxd_s2;
  assign w_fall = r_rxd_d & ~r_rxd_s2;

  // Frame settings track the inputs only while idle, so a frame in flight is unaffected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_baud_lat  <= '0;
      r_par_lat   <= '0;
      r_stop2_lat <= 1'b0;
    end else if (r_state == IDLE) begin
      r_baud_lat  <= baud_select;
      r_par_lat   <= parity_mode;
      r_stop2_lat <= stop2;
    end
  end

  always_comb begin
    w_div_val = CNT_W'(div_of(300));
    case (r_baud_lat)
      3'd0:    w_div_val = CNT_W'(div_of(300));
      3'd1:    w_div_val = CNT_W'(div_of(1200));
      3'd2:    w_div_val = CNT_W'(div_of(4800));
      3'd3:    w_div_val = CNT_W'(div_of(9600));
      3'd4:    w_div_val = CNT_W'(div_of(19200));
      3'd5:    w_div_val = CNT_W'(div_of(38400));
      3'd6:    w_div_val = CNT_W'(div_of(57600));
      default: w_div_val = CNT_W'(div_of(115200));
    endcase
  end

  // Divider is held at zero while idle so tick phase is aligned to the start edge.
  assign w_tick = (r_state != IDLE) && (r_div_cnt == w_div_val - CNT_W'(1));
  assign w_mid  = w_tick && (r_tick == 4'd7);
  assign w_end  = w_tick && (r_tick == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    r_div_cnt <= '0;
    else if (r_state == IDLE || !Rx_EN || w_tick)  r_div_cnt <= '0;
    else                                           r_div_cnt <= r_div_cnt + CNT_W'(1);
  end

  assign w_par_en    = (r_par_lat == 2'b01) || (r_par_lat == 2'b10);
  assign w_par_exp   = r_par_lat[1] ? ~(^r_shift) : ^r_shift;
  assign w_done_ferr = r_ferr | ~w_rxd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else if (r_state == IDLE || !Rx_EN) begin
      r_tick  <= '0;
      r_bit   <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_tick)                   r_tick  <= r_tick + 4'd1;
      if (r_state == DATA && w_mid) r_shift <= {w_rxd, r_shift[DATA_W-1:1]};
      if (r_state == DATA && w_end) r_bit   <= r_bit + BIT_W'(1);
      if (r_state == PARITY && w_mid) r_perr <= w_rxd ^ w_par_exp;
      if (r_state == STOP1 && w_mid && !w_rxd) r_ferr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE:   if (Rx_EN && w_fall) w_state_next = START;
      START: begin
        if (w_mid && w_rxd) w_state_next = IDLE;
        else if (w_end)     w_state_next = DATA;
      end
      DATA:   if (w_end && r_bit == BIT_W'(DATA_W - 1))
                w_state_next = w_par_en ? PARITY : STOP1;
      PARITY: if (w_end) w_state_next = STOP1;
      STOP1: begin
        if (w_mid && !r_stop2_lat) begin
          w_frame_done = 1'b1;
          w_state_next = IDLE;
        end else if (w_end) begin
          w_state_next = STOP2;
        end
      end
      STOP2: begin
        if (w_mid) begin
          w_frame_done = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (!Rx_EN) begin
      w_state_next = IDLE;
      w_frame_done = 1'b0;
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_pop   = Rx_READY & w_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the frame.
  assign w_push  = w_frame_done & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_shift, r_perr, w_done_ferr};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (!Rx_EN)                                r_overrun <= 1'b0;
      else if (w_frame_done && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign Rx_VALID   = w_valid;
  assign Rx_DATA    = w_valid ? w_head[ENT_W-1:2] : '0;
  assign Rx_PERROR  = w_valid & w_head[1];
  assign Rx_FERROR  = w_valid & w_head[0];
  assign Rx_OVERRUN = r_overrun;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 100 MHz / 115200 baud (54 clk per tick, 864 per bit).
module tb_uart_rx_fifo;
  localparam int BIT      = 864;
  localparam int STOP_LEN = 500;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic [1:0] parity_mode;
  logic       stop2;
  logic       RxD;
  logic       Rx_READY;
  logic [7:0] Rx_DATA;
  logic       Rx_PERROR, Rx_FERROR, Rx_VALID, Rx_OVERRUN;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo #(.CLK_HZ(100000000), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .Rx_EN(Rx_EN),
    .parity_mode(parity_mode), .stop2(stop2), .RxD(RxD), .Rx_READY(Rx_READY),
    .Rx_DATA(Rx_DATA), .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR),
    .Rx_VALID(Rx_VALID), .Rx_OVERRUN(Rx_OVERRUN), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a full frame; the last stop bit is shortened since it is sampled at mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic has_par,
                            input logic par_bit, input logic stop_val);
    RxD = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      wait_cyc(BIT);
    end
    if (has_par) begin
      RxD = par_bit;
      wait_cyc(BIT);
    end
    RxD = stop_val;
    wait_cyc(STOP_LEN);
    RxD = 1'b1;
  endtask

  task automatic pop();
    Rx_READY = 1'b1;
    wait_cyc(1);
    Rx_READY = 1'b0;
  endtask

  initial begin
    reset = 1'b0; baud_select = 3'b111; Rx_EN = 1'b1; parity_mode = 2'b00;
    stop2 = 1'b0; RxD = 1'b1; Rx_READY = 1'b0;
    wait_cyc(3);
    check("rst_valid", 16'(Rx_VALID), 16'h0);
    check("rst_data", 16'(Rx_DATA), 16'h0);
    check("rst_perr", 16'(Rx_PERROR), 16'h0);
    check("rst_ferr", 16'(Rx_FERROR), 16'h0);
    check("rst_ovr", 16'(Rx_OVERRUN), 16'h0);
    check("rst_count", 16'(fifo_count), 16'h0);
    reset = 1'b1;
    wait_cyc(5);

    parity_mode = 2'b01;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1);
    check("f55_valid", 16'(Rx_VALID), 16'h1);
    check("f55_data", 16'(Rx_DATA), 16'h55);
    check("f55_perr", 16'(Rx_PERROR), 16'h0);
    check("f55_ferr", 16'(Rx_FERROR), 16'h0);
    check("f55_count", 16'(fifo_count), 16'h1);
    pop();
    check("f55_popped", 16'(Rx_VALID), 16'h0);

    parity_mode = 2'b10;
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1);
    check("fa3_data", 16'(Rx_DATA), 16'hA3);
    check("fa3_perr", 16'(Rx_PERROR), 16'h1);
    check("fa3_ferr", 16'(Rx_FERROR), 16'h0);
    pop();

    parity_mode = 2'b00;
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    check("f0f_data", 16'(Rx_DATA), 16'h0F);
    check("f0f_ferr", 16'(Rx_FERROR), 16'h1);
    check("f0f_perr", 16'(Rx_PERROR), 16'h0);
    pop();
    check("f0f_count", 16'(fifo_count), 16'h0);

    RxD = 1'b0;
    wait_cyc(4 * 54);
    RxD = 1'b1;
    wait_cyc(600);
    check("glitch_valid", 16'(Rx_VALID), 16'h0);
    check("glitch_count", 16'(fifo_count), 16'h0);

    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    check("ovr_count", 16'(fifo_count), 16'h4);
    check("ovr_flag", 16'(Rx_OVERRUN), 16'h1);
    check("ovr_head", 16'(Rx_DATA), 16'h01);

    Rx_EN = 1'b0;
    wait_cyc(1);
    check("en_clr_ovr", 16'(Rx_OVERRUN), 16'h0);
    check("en_keep_cnt", 16'(fifo_count), 16'h4);
    Rx_EN = 1'b1;
    wait_cyc(2);

    // Frame write lands on the 8211th posedge after the start bit begins.
    fork
      send_frame(8'h06, 1'b0, 1'b0, 1'b1);
      begin
        repeat (8210) @(posedge clk);
        @(negedge clk);
        check("simul_pre_cnt", 16'(fifo_count), 16'h4);
        check("simul_pre_head", 16'(Rx_DATA), 16'h01);
        Rx_READY = 1'b1;
        @(negedge clk);
        Rx_READY = 1'b0;
        check("simul_cnt", 16'(fifo_count), 16'h4);
        check("simul_ovr", 16'(Rx_OVERRUN), 16'h0);
        check("simul_head", 16'(Rx_DATA), 16'h02);
      end
    join
    pop();
    check("drain_03", 16'(Rx_DATA), 16'h03);
    pop();
    check("drain_04", 16'(Rx_DATA), 16'h04);
    pop();
    check("drain_06", 16'(Rx_DATA), 16'h06);
    check("drain_cnt", 16'(fifo_count), 16'h1);

    RxD = 1'b0;
    wait_cyc(BIT + 400);
    reset = 1'b0;
    RxD = 1'b1;
    wait_cyc(5);
    check("mid_rst_valid", 16'(Rx_VALID), 16'h0);
    check("mid_rst_data", 16'(Rx_DATA), 16'h0);
    check("mid_rst_count", 16'(fifo_count), 16'h0);
    check("mid_rst_flags", 16'({Rx_PERROR, Rx_FERROR, Rx_OVERRUN}), 16'h0);
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(100);
    check("post_rst_idle", 16'(Rx_VALID), 16'h0);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("f3c_valid", 16'(Rx_VALID), 16'h1);
    check("f3c_data", 16'(Rx_DATA), 16'h3C);
    check("f3c_count", 16'(fifo_count), 16'h1);
    check("f3c_flags", 16'({Rx_PERROR, Rx_FERROR}), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
